stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 139 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: two debounced push-buttons drive an IDLE/RUN/PAUSE
// FSM, and a prescaled tick advances a 00..59 BCD count.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       running,
  output logic       wrap
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  // Button index 0 is start, index 1 is clear.
  logic [1:0]    raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [1:0]    armed;
  logic [1:0]    sync_ok;
  logic [CW-1:0] deb_cnt [2];
  logic [1:0]    press;

  state_t        state;
  state_t        next_state;
  logic [PW-1:0] presc;
  logic          tick;

  assign raw = {btn_clear, btn_start};

  // sync_ok marks when the synchronizer chain holds real samples after reset,
  // so a button held through reset is only armed once it is seen released.
  // Synchronize, debounce, and track the previous debounced level per button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a  <= '0;
      sync_b  <= '0;
      deb     <= '0;
      deb_d   <= '0;
      armed   <= '0;
      sync_ok <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      deb_d   <= deb;
      sync_ok <= {sync_ok[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
        if (sync_ok[1] && !sync_b[i] && !deb[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign press = armed & deb & ~deb_d;
  assign tick  = (state == RUN) && (presc == PW'(TICK_DIV - 1));

  // Next-state logic; clear has priority over start.
  always_comb begin
    next_state = state;
    if (press[1]) begin
      next_state = IDLE;
    end else if (press[0]) begin
      case (state)
        IDLE:    next_state = RUN;
        RUN:     next_state = PAUSE;
        PAUSE:   next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  // State register with the registered running flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
    end
  end

  // Prescaler: advances only in RUN, holds in PAUSE, zeroed when going IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (next_state == IDLE) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // BCD count 00..59 with a one-cycle wrap pulse; going IDLE beats a tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_tens <= 4'd0;
      digit_ones <= 4'd0;
      wrap       <= 1'b0;
    end else if (next_state == IDLE) begin
      digit_tens <= 4'd0;
      digit_ones <= 4'd0;
      wrap       <= 1'b0;
    end else if (tick) begin
      if (digit_ones < 4'd9) begin
        digit_ones <= digit_ones + 4'd1;
        wrap       <= 1'b0;
      end else if (digit_tens < 4'd5) begin
        digit_ones <= 4'd0;
        digit_tens <= digit_tens + 4'd1;
        wrap       <= 1'b0;
      end else begin
        digit_ones <= 4'd0;
        digit_tens <= 4'd0;
        wrap       <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=3.
// Observed word is {running, wrap, digit_tens, digit_ones}.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_start;
  logic       btn_clear;
  logic [3:0] digit_tens;
  logic [3:0] digit_ones;
  logic       running;
  logic       wrap;

  logic [9:0] exp_q [$];
  int         errors;
  int         checks;

  stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .digit_tens (digit_tens),
    .digit_ones (digit_ones),
    .running    (running),
    .wrap       (wrap)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 unit after the last edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic r, input logic w, input logic [3:0] t, input logic [3:0] o);
    exp_q.push_back({r, w, t, o});
  endtask

  // Pop the oldest expectation and compare against the full output word.
  task automatic check(input string tag);
    logic [9:0] obs;
    logic [9:0] exp_v;
    obs = {running, wrap, digit_tens, digit_ones};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  // Compare only the running flag.
  task automatic check_run(input string tag, input logic r);
    logic [9:0] obs;
    logic [9:0] exp_v;
    exp_q.push_back({9'd0, r});
    obs = {9'd0, running};
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;

    // Reset state.
    cyc(3);
    push_exp(0, 0, 4'd0, 4'd0); check("reset");
    rst_n = 1'b1;
    cyc(5);
    push_exp(0, 0, 4'd0, 4'd0); check("post_reset_idle");

    // Clean start press: running exactly 6 edges after raw rise.
    btn_start = 1'b1;
    cyc(5); push_exp(0, 0, 4'd0, 4'd0); check("start_lat5");
    cyc(1); push_exp(1, 0, 4'd0, 4'd0); check("start_lat6");
    cyc(2); btn_start = 1'b0;
    cyc(1); push_exp(1, 0, 4'd0, 4'd0); check("first_tick_pre");
    cyc(1); push_exp(1, 0, 4'd0, 4'd1); check("first_tick");

    // Clear back to IDLE.
    btn_clear = 1'b1;
    cyc(8); btn_clear = 1'b0;
    cyc(10); push_exp(0, 0, 4'd0, 4'd0); check("clear_idle");

    // Bouncing start: 1,0,1,0 then stable high gives a single event.
    btn_start = 1'b1; cyc(1);
    btn_start = 1'b0; cyc(1);
    btn_start = 1'b1; cyc(1);
    btn_start = 1'b0; cyc(1);
    btn_start = 1'b1;
    cyc(5); check_run("bounce_lat5", 1'b0);
    cyc(1); check_run("bounce_lat6", 1'b1);
    cyc(10); btn_start = 1'b0;
    cyc(10); check_run("bounce_single_event", 1'b1);

    // Clear, then run to 58 and through the rollover.
    btn_clear = 1'b1;
    cyc(8); btn_clear = 1'b0;
    cyc(10); push_exp(0, 0, 4'd0, 4'd0); check("clear_idle2");
    btn_start = 1'b1;
    cyc(8); btn_start = 1'b0;
    cyc(230); push_exp(1, 0, 4'd5, 4'd8); check("at_58");
    cyc(3);   push_exp(1, 0, 4'd5, 4'd8); check("hold_58");
    cyc(1);   push_exp(1, 0, 4'd5, 4'd9); check("at_59");
    cyc(4);   push_exp(1, 1, 4'd0, 4'd0); check("wrap_00");
    cyc(1);   push_exp(1, 0, 4'd0, 4'd0); check("wrap_one_cycle");

    // Pause while the prescaler is at 2, hold, then resume.
    cyc(4); btn_start = 1'b1;
    cyc(6);  push_exp(0, 0, 4'd0, 4'd2); check("paused");
    cyc(14); btn_start = 1'b0;
    cyc(10); push_exp(0, 0, 4'd0, 4'd2); check("pause_frozen");
    btn_start = 1'b1;
    cyc(6);  push_exp(1, 0, 4'd0, 4'd2); check("resume");
    cyc(1);  push_exp(1, 0, 4'd0, 4'd3); check("resume_tick");
    cyc(1);  btn_start = 1'b0;
    cyc(3);  push_exp(1, 0, 4'd0, 4'd4); check("resume_next");

    // Start and clear events together at 37, coinciding with a tick.
    cyc(130); push_exp(1, 0, 4'd3, 4'd6); check("at_36");
    btn_start = 1'b1; btn_clear = 1'b1;
    cyc(2); push_exp(1, 0, 4'd3, 4'd7); check("at_37");
    cyc(3); push_exp(1, 0, 4'd3, 4'd7); check("hold_37");
    cyc(1); push_exp(0, 0, 4'd0, 4'd0); check("clear_wins");
    cyc(2); btn_start = 1'b0; btn_clear = 1'b0;
    cyc(10); push_exp(0, 0, 4'd0, 4'd0); check("clear_wins_idle");

    // Reset at 42 with start held; no event until released and pressed.
    btn_start = 1'b1;
    cyc(8); btn_start = 1'b0;
    cyc(166); push_exp(1, 0, 4'd4, 4'd2); check("at_42");
    btn_start = 1'b1;
    cyc(2); rst_n = 1'b0;
    cyc(2); push_exp(0, 0, 4'd0, 4'd0); check("reset_mid");
    rst_n = 1'b1;
    cyc(20); push_exp(0, 0, 4'd0, 4'd0); check("held_no_event");
    btn_start = 1'b0;
    cyc(10); push_exp(0, 0, 4'd0, 4'd0); check("released_idle");
    btn_start = 1'b1;
    cyc(5); push_exp(0, 0, 4'd0, 4'd0); check("repress_lat5");
    cyc(1); push_exp(1, 0, 4'd0, 4'd0); check("repress_run");
    btn_start = 1'b0;
    cyc(4);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
